// File: rtl/decode_rob_queue.sv
// Elastic Decode->ROB queue: DEPTH-entry circular buffer of IPC-lane bundles with
// valid/ready on both sides, synchronous flush, dequeue-only halt and optional bubble drop.
module decode_rob_queue #(
  parameter int IPC          = 1,
  parameter int DATA_WIDTH   = 32,
  parameter int EXEC_WIDTH   = 4,
  parameter int DEPTH        = 4,
  parameter int DROP_BUBBLES = 1,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       halt,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IPC-1:0]             rtype_in,
  input  logic [IPC-1:0]             itype_in,
  input  logic [IPC-1:0]             stype_in,
  input  logic [IPC*DATA_WIDTH-1:0]  imm_in,
  input  logic [IPC*EXEC_WIDTH-1:0]  exec_id_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IPC-1:0]             rtype_out,
  output logic [IPC-1:0]             itype_out,
  output logic [IPC-1:0]             stype_out,
  output logic [IPC*DATA_WIDTH-1:0]  imm_out,
  output logic [IPC*EXEC_WIDTH-1:0]  exec_id_out,
  output logic [CW-1:0]              count
);

  localparam int AW = CW - 1;
  localparam int EW = 3*IPC + IPC*DATA_WIDTH + IPC*EXEC_WIDTH;

  logic [CW-1:0] head, tail;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head_ent;
  logic          empty, full, bubble, store, deq;

  // Pointers carry a wrap bit so full and empty are distinguishable without a counter.
  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

  assign in_ready  = ~full & ~flush;
  assign out_valid = ~empty;
  assign bubble    = ~|(rtype_in | itype_in | stype_in);
  // flush is folded in through in_ready, so a store never races a clear.
  assign store     = in_valid & in_ready & ~((DROP_BUBBLES != 0) & bubble);
  assign deq       = ~empty & out_ready & ~halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (store) tail <= tail + CW'(1);
      if (deq)   head <= head + CW'(1);
    end
  end

  // Payload is not reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (store) mem[tail[AW-1:0]] <= {rtype_in, itype_in, stype_in, imm_in, exec_id_in};
  end

  assign head_ent = empty ? '0 : mem[head[AW-1:0]];
  assign {rtype_out, itype_out, stype_out, imm_out, exec_id_out} = head_ent;
  assign count = tail - head;

endmodule

// File: tb/tb_decode_rob_queue.sv
// Bench for decode_rob_queue: table vectors plus scoreboard-driven fill, stream,
// flush, bubble and async-reset sequences. A second instance has bubble drop disabled.
module tb_decode_rob_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        rt, it, st;
    logic [31:0] imm;
    logic [3:0]  eid;
  } bun_t;

  typedef struct {
    logic        vld, ordy, hlt, fl;
    bun_t        b;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic [31:0] e_imm;
    logic [3:0]  e_eid;
  } vec_t;

  logic clk = 0, rst = 1, flush = 0, halt = 0, in_valid = 0, out_ready = 0;
  bun_t cur = '0;

  logic        in_ready, out_valid, rtype_out, itype_out, stype_out;
  logic [31:0] imm_out;
  logic [3:0]  exec_id_out;
  logic [2:0]  count;
  logic        in_ready_nd, out_valid_nd, rtype_out_nd, itype_out_nd, stype_out_nd;
  logic [31:0] imm_out_nd;
  logic [3:0]  exec_id_out_nd;
  logic [2:0]  count_nd;
  bun_t        outb;

  assign outb = {rtype_out, itype_out, stype_out, imm_out, exec_id_out};

  always #5 clk = ~clk;

  decode_rob_queue #(.IPC(1), .DATA_WIDTH(32), .EXEC_WIDTH(4), .DEPTH(DEPTH), .DROP_BUBBLES(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .halt(halt),
    .in_valid(in_valid), .in_ready(in_ready),
    .rtype_in(cur.rt), .itype_in(cur.it), .stype_in(cur.st),
    .imm_in(cur.imm), .exec_id_in(cur.eid),
    .out_valid(out_valid), .out_ready(out_ready),
    .rtype_out(rtype_out), .itype_out(itype_out), .stype_out(stype_out),
    .imm_out(imm_out), .exec_id_out(exec_id_out), .count(count));

  decode_rob_queue #(.IPC(1), .DATA_WIDTH(32), .EXEC_WIDTH(4), .DEPTH(DEPTH), .DROP_BUBBLES(0)) dut_nd (
    .clk(clk), .rst(rst), .flush(flush), .halt(halt),
    .in_valid(in_valid), .in_ready(in_ready_nd),
    .rtype_in(cur.rt), .itype_in(cur.it), .stype_in(cur.st),
    .imm_in(cur.imm), .exec_id_in(cur.eid),
    .out_valid(out_valid_nd), .out_ready(out_ready),
    .rtype_out(rtype_out_nd), .itype_out(itype_out_nd), .stype_out(stype_out_nd),
    .imm_out(imm_out_nd), .exec_id_out(exec_id_out_nd), .count(count_nd));

  int   n_chk = 0, n_fail = 0, npop = 0;
  bun_t sb[$];
  logic last_acc = 0;
  vec_t tbl[9];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic exp_rdy, stored, deq;
    @(negedge clk);
    exp_rdy = (sb.size() < DEPTH) && !flush;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, sb.size() > 0);
    check("count", count, sb.size());
    if (sb.size() > 0) check("head_bundle", outb, sb[0]);
    else               check("empty_outs_zero", outb, '0);
    last_acc = in_valid && exp_rdy;
    stored   = last_acc && (cur.rt | cur.it | cur.st);
    deq      = (sb.size() > 0) && out_ready && !halt;
    @(posedge clk);
    #1;
    if (flush) sb.delete();
    else begin
      if (deq) begin void'(sb.pop_front()); npop++; end
      if (stored) sb.push_back(cur);
    end
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; halt = 0; in_valid = 0; out_ready = 0; cur = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    sb.delete();
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outs_zero", outb, '0);
  endtask

  task automatic send(bun_t b);
    cur = b;
    in_valid = 1;
    last_acc = 0;
    for (int t = 0; t < 50; t++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", 0, 1);
  endtask

  function automatic bun_t mkb(int i);
    bun_t b;
    b.rt = (i % 3 == 0); b.it = (i % 3 == 1); b.st = (i % 3 == 2);
    b.imm = $urandom; b.eid = 4'(i);
    return b;
  endfunction

  function automatic vec_t mkv(logic vld, logic ordy, logic hlt, logic fl, logic rt, logic it,
                               logic st, logic [31:0] imm, logic [3:0] eid, logic [2:0] c,
                               logic ov, logic [31:0] ei, logic [3:0] ee);
    vec_t v;
    v.vld = vld; v.ordy = ordy; v.hlt = hlt; v.fl = fl;
    v.b = {rt, it, st, imm, eid};
    v.e_cnt = c; v.e_ov = ov; v.e_imm = ei; v.e_eid = ee;
    return v;
  endfunction

  initial begin
    int sent, pop0, cyc;
    //            vld ordy hlt fl rt it st imm    eid   cnt ov imm    eid
    tbl[0] = mkv(1, 0, 0, 0, 1, 0, 0, 32'hA5, 4'd3, 1, 1, 32'hA5, 4'd3);
    tbl[1] = mkv(1, 0, 0, 0, 0, 1, 0, 32'h11, 4'd1, 2, 1, 32'hA5, 4'd3);
    tbl[2] = mkv(1, 0, 0, 0, 0, 0, 0, 32'hFF, 4'd9, 2, 1, 32'hA5, 4'd3);
    tbl[3] = mkv(0, 1, 0, 0, 0, 0, 0, 32'h0,  4'd0, 1, 1, 32'h11, 4'd1);
    tbl[4] = mkv(1, 1, 0, 0, 0, 0, 1, 32'h22, 4'd2, 1, 1, 32'h22, 4'd2);
    tbl[5] = mkv(0, 1, 1, 0, 0, 0, 0, 32'h0,  4'd0, 1, 1, 32'h22, 4'd2);
    tbl[6] = mkv(0, 1, 0, 0, 0, 0, 0, 32'h0,  4'd0, 0, 0, 32'h0,  4'd0);
    tbl[7] = mkv(1, 0, 0, 1, 1, 0, 0, 32'h33, 4'd5, 0, 0, 32'h0,  4'd0);
    tbl[8] = mkv(1, 0, 0, 0, 1, 0, 0, 32'h44, 4'd6, 1, 1, 32'h44, 4'd6);

    do_reset();
    foreach (tbl[i]) begin
      in_valid = tbl[i].vld; out_ready = tbl[i].ordy; halt = tbl[i].hlt; flush = tbl[i].fl;
      cur = tbl[i].b;
      cycle();
      check($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_imm", i), imm_out, tbl[i].e_imm);
      check($sformatf("tbl%0d_eid", i), exec_id_out, tbl[i].e_eid);
    end
    in_valid = 0; flush = 0; halt = 0;

    // Fill to DEPTH with the sink stalled, then release and drain in order.
    do_reset();
    for (int k = 0; k < 4; k++) send(mkb(k));
    cur = mkb(4);
    repeat (2) cycle();
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    out_ready = 1;
    send(cur);
    in_valid = 0;
    for (int t = 0; t < 20 && sb.size() > 0; t++) cycle();
    check("fill_drained", count, 0);

    // Streaming 100 bundles with a 3-cycle halt pulse.
    do_reset();
    out_ready = 1;
    sent = 0; pop0 = npop;
    cur = mkb(0);
    for (cyc = 0; cyc < 600; cyc++) begin
      in_valid = (sent < 100);
      halt = (cyc >= 30 && cyc < 33);
      cycle();
      check("count_le_depth", count <= DEPTH, 1);
      if (last_acc && sent < 100) begin
        sent++;
        cur = mkb(sent);
      end
      if (sent == 100 && sb.size() == 0) break;
    end
    in_valid = 0; halt = 0;
    check("stream_sent", sent, 100);
    check("stream_popped", npop - pop0, 100);

    // Flush with three stored and a bundle in flight.
    do_reset();
    for (int k = 0; k < 3; k++) send(mkb(k));
    cur = mkb(7);
    flush = 1;
    cycle();
    flush = 0; in_valid = 0;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_outs_zero", outb, '0);
    cycle();

    // All-bubble bundle: dropped by one instance, stored by the other.
    do_reset();
    cur = '0; cur.imm = 32'h77;
    in_valid = 1;
    cycle();
    in_valid = 0;
    check("bubble_drop_count", count, 0);
    check("bubble_keep_count", count_nd, 1);
    check("bubble_keep_valid", out_valid_nd, 1);

    // Async reset mid-cycle with two bundles stored.
    do_reset();
    for (int k = 0; k < 2; k++) send(mkb(k));
    in_valid = 0;
    check("pre_arst_count", count, 2);
    #2 rst = 1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_count", count, 0);
    check("arst_outs_zero", outb, '0);
    @(negedge clk);
    #1 rst = 0;
    sb.delete();
    @(posedge clk);
    #1;
    check("post_arst_in_ready", in_ready, 1);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
